// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the pipeline hazard controller.
// Holds the stage/buffer indices, the controller state encoding, the
// pause/flush masks and the wait-counter width helper.
package core_pkg;

    // Pipeline buffer indices (bit positions in pause/flush)
    localparam int STG_IF_ID  = 0;
    localparam int STG_ID_EX  = 1;
    localparam int STG_EX_MEM = 2;
    localparam int STG_MEM_WB = 3;

    // Controller state
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_EX_WAIT  = 2'd2
    } state_t;

    // Single-buffer masks
    localparam logic [3:0] BUF_IF_ID  = 4'(1 << STG_IF_ID);
    localparam logic [3:0] BUF_ID_EX  = 4'(1 << STG_ID_EX);
    localparam logic [3:0] BUF_EX_MEM = 4'(1 << STG_EX_MEM);
    localparam logic [3:0] BUF_MEM_WB = 4'(1 << STG_MEM_WB);

    // Composite masks used by the controller
    localparam logic [3:0] MASK_NONE      = 4'b0000;
    localparam logic [3:0] MASK_ALL       = BUF_IF_ID | BUF_ID_EX | BUF_EX_MEM | BUF_MEM_WB;
    // Front end: held during an EX wait, squashed on a taken branch
    localparam logic [3:0] MASK_FRONT     = BUF_IF_ID | BUF_ID_EX;
    // Bubble pushed into EX/MEM while the EX unit is still busy
    localparam logic [3:0] MASK_EX_BUBBLE = BUF_EX_MEM;
    // Load-use: hold the consumer in IF/ID, send a bubble into ID/EX
    localparam logic [3:0] MASK_LU_PAUSE  = BUF_IF_ID;
    localparam logic [3:0] MASK_LU_FLUSH  = BUF_ID_EX;
    // Aborted memory access never reaches writeback
    localparam logic [3:0] MASK_ABORT     = BUF_MEM_WB;

    // Wait counter width: wide enough for TIMEOUT, never below 8 bits
    function automatic int wait_cnt_w(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 8) ? 8 : w;
    endfunction

endpackage

// File: rtl/pipe_ctrl_wait_timer.sv
// wait_timer: saturating up-counter with load-clear and a terminal-count
// flag. Clear has priority over increment; the count stops at TIMEOUT.
module wait_timer
    import core_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = wait_cnt_w(TIMEOUT)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count;

    // Count wait cycles; reset or clear returns the count to zero
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && !tc) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count >= TC_VAL);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard/stall controller for a 5-stage pipeline.
// Drives per-buffer pause and flush from the registered state plus the
// current hazard inputs (no added latency).
// Optional feature: define PIPE_CTRL_PERF_EN to add the stall_cycles and
// flush_events performance counters; without it those ports do not exist.
module pipe_ctrl
    import core_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_use,
    input  logic        ex_busy,
    input  logic        dmem_req,
    input  logic        dmem_ack,
    input  logic        branch_taken,
    output logic [3:0]  pause,
    output logic [3:0]  flush,
    output logic        mem_err
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
`endif
);

    state_t state;
    state_t state_nxt;
    logic   branch_pend;
    logic   pend_nxt;
    logic   mem_wait;
    logic   timeout;
    logic   tc;

    // A data access is still outstanding; ack without a request means nothing
    assign mem_wait = dmem_req & ~dmem_ack;
    // Abort once the wait has lasted TIMEOUT cycles and memory still has not answered
    assign timeout  = (state == ST_MEM_WAIT) & mem_wait & tc;

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_mem_timer (
        .clk   (clk),
        .reset (reset),
        .clear (~mem_wait | timeout),
        .inc   (mem_wait),
        .tc    (tc)
    );

    // State register and pending-branch flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RUN;
            branch_pend <= 1'b0;
        end else begin
            state       <= state_nxt;
            branch_pend <= pend_nxt;
        end
    end

    // Next state: memory wait beats EX wait; anything else returns to RUN.
    // A branch that cannot flush this cycle (wait in progress or starting)
    // is remembered and replayed on the first cycle the state is RUN.
    always_comb begin
        state_nxt = ST_RUN;
        pend_nxt  = branch_pend;
        if (mem_wait && !timeout) begin
            state_nxt = ST_MEM_WAIT;
        end else if (!timeout && ex_busy) begin
            state_nxt = ST_EX_WAIT;
        end
        if (state == ST_RUN && !mem_wait && !ex_busy) begin
            pend_nxt = 1'b0;
        end else if (branch_taken) begin
            pend_nxt = 1'b1;
        end
    end

    // Outputs: priority memory wait > ex_busy > branch > load_use; the exit
    // cycle of a wait (ack or ex_busy dropping) only releases the pipeline
    always_comb begin
        pause   = MASK_NONE;
        flush   = MASK_NONE;
        mem_err = 1'b0;
        if (reset) begin
            pause   = MASK_NONE;
        end else if (timeout) begin
            mem_err = 1'b1;
            flush   = MASK_ABORT;
        end else if (mem_wait) begin
            pause   = MASK_ALL;
        end else if (ex_busy) begin
            pause   = MASK_FRONT;
            flush   = MASK_EX_BUBBLE;
        end else if (state == ST_RUN) begin
            if (branch_taken || branch_pend) begin
                flush = MASK_FRONT;
            end else if (load_use) begin
                pause = MASK_LU_PAUSE;
                flush = MASK_LU_FLUSH;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    // Performance counters: cycles with any pause, cycles with any flush
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (|pause) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (|flush) begin
                flush_events <= flush_events + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vector table for the corner cases, then random
// stimulus compared against a cycle-count based reference model.
module tb_pipe_ctrl;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_use;
    logic       ex_busy;
    logic       dmem_req;
    logic       dmem_ack;
    logic       branch_taken;
    logic [3:0] pause;
    logic [3:0] flush;
    logic       mem_err;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_events;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: consecutive stalled memory cycles, whether the
    // previous cycle was an EX wait, and an unserved branch.
    int   m_mem  = 0;
    bit   m_ex   = 1'b0;
    bit   m_pend = 1'b0;
    int unsigned m_stall = 0;
    int unsigned m_flush = 0;

    pipe_ctrl #(
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load_use     (load_use),
        .ex_busy      (ex_busy),
        .dmem_req     (dmem_req),
        .dmem_ack     (dmem_ack),
        .branch_taken (branch_taken),
        .pause        (pause),
        .flush        (flush),
        .mem_err      (mem_err)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] in;   // {reset, load_use, ex_busy, dmem_req, dmem_ack, branch_taken}
        logic [3:0] p;
        logic [3:0] f;
        logic       e;
        string      name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [5:0] in, input logic [3:0] p, input logic [3:0] f,
                       input logic e, input string name);
        vec_t v;
        v.in = in; v.p = p; v.f = f; v.e = e; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model for one cycle; returns expected outputs and advances
    task automatic model_step(input logic r, input logic lu, input logic eb,
                              input logic rq, input logic ak, input logic br,
                              output logic [3:0] p, output logic [3:0] f, output logic e);
        bit stalled;
        bit running;
        p = 4'b0000; f = 4'b0000; e = 1'b0;
        if (r) begin
            m_mem = 0; m_ex = 1'b0; m_pend = 1'b0;
        end else begin
            stalled = rq && !ak;
            running = (m_mem == 0) && !m_ex;
            if (stalled && m_mem >= TO) begin
                e = 1'b1; f = 4'b1000;
                m_mem = 0; m_ex = 1'b0;
                if (br) m_pend = 1'b1;
            end else if (stalled) begin
                p = 4'b1111;
                m_mem++; m_ex = 1'b0;
                if (br) m_pend = 1'b1;
            end else if (eb) begin
                p = 4'b0011; f = 4'b0100;
                m_mem = 0; m_ex = 1'b1;
                if (br) m_pend = 1'b1;
            end else if (!running) begin
                m_mem = 0; m_ex = 1'b0;
                if (br) m_pend = 1'b1;
            end else if (br || m_pend) begin
                f = 4'b0011; m_pend = 1'b0;
            end else if (lu) begin
                p = 4'b0001; f = 4'b0010;
            end
        end
    endtask

    // Apply one cycle of inputs; sample outputs on the falling edge
    task automatic cycle(input logic [5:0] in, output logic [3:0] mp,
                         output logic [3:0] mf, output logic me);
        @(posedge clk);
        #1;
        {reset, load_use, ex_busy, dmem_req, dmem_ack, branch_taken} = in;
        @(negedge clk);
`ifdef PIPE_CTRL_PERF_EN
        chk("stall_cycles", stall_cycles, m_stall);
        chk("flush_events", flush_events, m_flush);
`endif
        model_step(in[5], in[4], in[3], in[2], in[1], in[0], mp, mf, me);
        if (in[5]) begin
            m_stall = 0; m_flush = 0;
        end else begin
            if (mp != 4'b0000) m_stall++;
            if (mf != 4'b0000) m_flush++;
        end
        chk("pause_flush_overlap", {28'd0, pause & flush}, 32'd0);
    endtask

    function automatic logic pct(input int p);
        return $urandom_range(0, 99) < p;
    endfunction

    initial begin
        logic [3:0] mp, mf;
        logic       me;
        logic [5:0] in;
        int         regime;

        {reset, load_use, ex_busy, dmem_req, dmem_ack, branch_taken} = 6'b100000;
        regime = 0;

        //    {rst,lu,eb,req,ack,br}   pause    flush    err
        add(6'b111101, 4'b0000, 4'b0000, 1'b0, "reset_all_inputs");
        add(6'b100000, 4'b0000, 4'b0000, 1'b0, "reset_idle");
        add(6'b000000, 4'b0000, 4'b0000, 1'b0, "idle");
        add(6'b010000, 4'b0001, 4'b0010, 1'b0, "load_use");
        add(6'b000000, 4'b0000, 4'b0000, 1'b0, "load_use_after");
        add(6'b000100, 4'b1111, 4'b0000, 1'b0, "memwait_1");
        add(6'b000100, 4'b1111, 4'b0000, 1'b0, "memwait_2");
        add(6'b000100, 4'b1111, 4'b0000, 1'b0, "memwait_3");
        add(6'b000110, 4'b0000, 4'b0000, 1'b0, "mem_ack");
        add(6'b010000, 4'b0001, 4'b0010, 1'b0, "run_after_ack");
        add(6'b000000, 4'b0000, 4'b0000, 1'b0, "idle2");
        add(6'b001000, 4'b0011, 4'b0100, 1'b0, "exwait_1");
        add(6'b001001, 4'b0011, 4'b0100, 1'b0, "exwait_2_branch");
        add(6'b001000, 4'b0011, 4'b0100, 1'b0, "exwait_3");
        add(6'b001000, 4'b0011, 4'b0100, 1'b0, "exwait_4");
        add(6'b001000, 4'b0011, 4'b0100, 1'b0, "exwait_5");
        add(6'b000000, 4'b0000, 4'b0000, 1'b0, "ex_exit");
        add(6'b000000, 4'b0000, 4'b0011, 1'b0, "pending_branch_flush");
        add(6'b000000, 4'b0000, 4'b0000, 1'b0, "pending_cleared");
        add(6'b000001, 4'b0000, 4'b0011, 1'b0, "branch");
        add(6'b010001, 4'b0000, 4'b0011, 1'b0, "branch_beats_load_use");
        add(6'b000000, 4'b0000, 4'b0000, 1'b0, "idle3");
        add(6'b000100, 4'b1111, 4'b0000, 1'b0, "to_wait_1");
        add(6'b000100, 4'b1111, 4'b0000, 1'b0, "to_wait_2");
        add(6'b000100, 4'b1111, 4'b0000, 1'b0, "to_wait_3");
        add(6'b000100, 4'b1111, 4'b0000, 1'b0, "to_wait_4");
        add(6'b000100, 4'b0000, 4'b1000, 1'b1, "timeout_abort");
        add(6'b000000, 4'b0000, 4'b0000, 1'b0, "after_timeout");
        add(6'b000010, 4'b0000, 4'b0000, 1'b0, "ack_without_req");
        add(6'b010010, 4'b0001, 4'b0010, 1'b0, "load_use_ack_no_req");
        add(6'b000100, 4'b1111, 4'b0000, 1'b0, "rst_wait_1");
        add(6'b100100, 4'b0000, 4'b0000, 1'b0, "reset_mid_memwait");
        add(6'b010000, 4'b0001, 4'b0010, 1'b0, "run_after_reset");
        add(6'b000100, 4'b1111, 4'b0000, 1'b0, "cnt_clr_1");
        add(6'b000100, 4'b1111, 4'b0000, 1'b0, "cnt_clr_2");
        add(6'b000100, 4'b1111, 4'b0000, 1'b0, "cnt_clr_3");
        add(6'b000100, 4'b1111, 4'b0000, 1'b0, "cnt_clr_4");
        add(6'b000100, 4'b0000, 4'b1000, 1'b1, "cnt_clr_timeout");
        add(6'b000000, 4'b0000, 4'b0000, 1'b0, "idle4");
        add(6'b001000, 4'b0011, 4'b0100, 1'b0, "rst_ex_1");
        add(6'b101000, 4'b0000, 4'b0000, 1'b0, "reset_mid_exwait");
        add(6'b010000, 4'b0001, 4'b0010, 1'b0, "run_after_ex_reset");
        add(6'b001000, 4'b0011, 4'b0100, 1'b0, "ex_then_mem");
        add(6'b001100, 4'b1111, 4'b0000, 1'b0, "mem_beats_ex");
        add(6'b001110, 4'b0011, 4'b0100, 1'b0, "ack_with_ex_busy");
        add(6'b000000, 4'b0000, 4'b0000, 1'b0, "ex_exit2");
        add(6'b000000, 4'b0000, 4'b0000, 1'b0, "idle5");
        add(6'b000100, 4'b1111, 4'b0000, 1'b0, "br_mem_1");
        add(6'b000111, 4'b0000, 4'b0000, 1'b0, "branch_on_ack");
        add(6'b000000, 4'b0000, 4'b0011, 1'b0, "branch_on_ack_replay");
        add(6'b000000, 4'b0000, 4'b0000, 1'b0, "idle6");

        foreach (vecs[i]) begin
            cycle(vecs[i].in, mp, mf, me);
            chk({vecs[i].name, ".pause"}, {28'd0, pause}, {28'd0, vecs[i].p});
            chk({vecs[i].name, ".flush"}, {28'd0, flush}, {28'd0, vecs[i].f});
            chk({vecs[i].name, ".mem_err"}, {31'd0, mem_err}, {31'd0, vecs[i].e});
        end

        // Random phase against the reference model
        for (int c = 0; c < 3000; c++) begin
            if (c % 16 == 0) regime = $urandom_range(0, 3);
            in = '0;
            in[5] = ($urandom_range(0, 199) == 0);
            in[4] = pct(30);
            in[0] = pct(20);
            case (regime)
                0: begin in[3] = pct(10); in[2] = pct(20); in[1] = pct(50); end
                1: begin in[3] = pct(10); in[2] = pct(90); in[1] = pct(8);  end
                2: begin in[3] = pct(70); in[2] = pct(15); in[1] = pct(50); end
                default: begin in[3] = pct(40); in[2] = pct(50); in[1] = pct(50); end
            endcase
            cycle(in, mp, mf, me);
            chk("rand.pause", {28'd0, pause}, {28'd0, mp});
            chk("rand.flush", {28'd0, flush}, {28'd0, mf});
            chk("rand.mem_err", {31'd0, mem_err}, {31'd0, me});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, max consecutive MEM_WAIT cycles before abort.
REQ-002 clk  input  1  clock; all state updates on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 load_use  input  1  ID instruction consumes load result currently in EX.
REQ-005 ex_busy  input  1  multi-cycle EX unit (mul/div) not done.
REQ-006 dmem_req  input  1  MEM stage has a data-memory access outstanding.
REQ-007 dmem_ack  input  1  data memory completes access this cycle.
REQ-008 branch_taken  input  1  EX resolves taken branch/jump this cycle.
REQ-009 pause  output  4  per-buffer hold; bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM, bit3 MEM/WB; drives each buffer's pause pin.
REQ-010 flush  output  4  per-buffer bubble insert, same bit order; ORed into that buffer's reset.
REQ-011 mem_err  output  1  one-cycle pulse on MEM_WAIT timeout.

Function
REQ-012 pause/flush/mem_err combinational from registered state plus current inputs; zero added latency.
REQ-013 States: RUN, MEM_WAIT, EX_WAIT; state register updates each posedge.
REQ-014 Priority per cycle: memory wait > ex_busy > branch_taken > load_use.
REQ-015 Memory wait (dmem_req & !dmem_ack, any state): pause=4'b1111, flush=0; next state MEM_WAIT.
REQ-016 In MEM_WAIT, dmem_ack high: pause=0 that cycle, next state RUN.
REQ-017 EX wait (ex_busy, no memory wait): pause=4'b0011, flush=4'b0100; next state EX_WAIT; leave to RUN first cycle ex_busy low.
REQ-018 branch_taken in RUN, no higher event: flush=4'b0011, pause=0, for exactly that cycle.
REQ-019 load_use in RUN, no higher event: pause=4'b0001, flush=4'b0010, one cycle only.
REQ-020 load_use with branch_taken same cycle: branch wins, load_use ignored.
REQ-021 branch_taken during MEM_WAIT/EX_WAIT: set branch_pend; flush=4'b0011 on first cycle back in RUN, then clear.
REQ-022 Never pause[i] and flush[i] high same bit same cycle.
REQ-023 Wait counter (8-bit min, width from TIMEOUT) counts MEM_WAIT cycles, clears on leaving MEM_WAIT.
REQ-024 Counter reaching TIMEOUT: mem_err=1 one cycle, flush=4'b1000, pause=0, next state RUN, counter cleared.
REQ-025 Inputs without dmem_req: dmem_ack ignored.

Reset
REQ-026 Reset: state RUN, branch_pend 0, wait counter 0; pause, flush, mem_err read 0 in every reset cycle regardless of inputs.
REQ-027 Reset mid MEM_WAIT or EX_WAIT abandons wait; no mem_err emitted.

Configuration
REQ-028 Macro PIPE_CTRL_PERF_EN defined: add outputs stall_cycles[31:0] (cycles with any pause bit) and flush_events[31:0] (cycles with any flush bit), wrap at 2^32, cleared on reset.
REQ-029 Macro undefined: those ports and counters absent; all other behaviour identical.

Structure
REQ-030 core_pkg holds stage index constants (STG_IF_ID=0..STG_MEM_WB=3), state enum, and 4-bit pause/flush mask constants.
REQ-031 Sub-module wait_timer: load-clear, increment, terminal-count flag; instantiated once for MEM_WAIT timeout.

Verification
REQ-032 load_use=1 one cycle in RUN -> pause=0001, flush=0010 that cycle, then 0000/0000.
REQ-033 dmem_req=1, dmem_ack low 3 cycles then high -> pause=1111 for 3 cycles, 0000 on ack cycle, state RUN next.
REQ-034 ex_busy 5 cycles with branch_taken pulse in cycle 2 -> pause=0011/flush=0100 x5, then flush=0011 first RUN cycle.
REQ-035 TIMEOUT=4, dmem_req held, no ack -> pause=1111 x4, then mem_err=1, flush=1000 one cycle.
REQ-036 reset asserted cycle 2 of MEM_WAIT -> outputs 0 same cycle, state RUN, no mem_err; PERF_EN build counters read 0.
